klotski_move_player: RTL and testbench

//  Consumer end of the solver's move stream: accepts blank-tile moves (U/D/L/R) over valid/ready,

---
 rtl/klotski_pkg.sv | 26 ++
 rtl/klotski_move_fifo.sv | 68 ++++++
 rtl/klotski_move_player.sv | 167 ++++++++++++++++
 tb/tb_klotski_move_player.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/klotski_pkg.sv
// Shared types for the klotski move player.
//  board_t  : [row][col] of 4-bit tiles, tile 0 = blank
//  pos_t    : {row, col} of the blank
//  dir_e    : blank move direction
//  state_e  : player control state
//  SOLVED_BOARD / is_solved : goal layout, 1..15 row-major with blank at [3][3]
package klotski_pkg;

  typedef logic [3:0][3:0][3:0] board_t;
  typedef logic [1:0][1:0]      pos_t;

  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;
  typedef enum logic [1:0] {ST_EMPTY, ST_LOAD, ST_RUN, ST_ERR}      state_e;

  localparam board_t SOLVED_BOARD = {
    4'd0,  4'd15, 4'd14, 4'd13,
    4'd12, 4'd11, 4'd10, 4'd9,
    4'd8,  4'd7,  4'd6,  4'd5,
    4'd4,  4'd3,  4'd2,  4'd1
  };

  function automatic logic is_solved(input board_t b);
    return b == SOLVED_BOARD;
  endfunction

endpackage

// File: rtl/klotski_move_fifo.sv
// Synchronous FIFO holding pending move tokens.
//  i_clk/i_rst : clock, async active-high reset
//  i_flush     : drop all entries (wins over push/pop)
//  i_push/i_data : write when not full
//  i_pop/o_data  : o_data is the head entry; pop advances when not empty
//  o_full/o_empty: occupancy flags
module klotski_move_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign o_full  = (count_q == (AW+1)'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_data  = mem_q[rd_ptr_q];
  assign push_ok = i_push && !o_full && !i_flush;
  assign pop_ok  = i_pop && !o_empty && !i_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // pointers wrap naturally since DEPTH is a power of two
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_d = count_q + (AW+1)'(1);
      else if (pop_ok && !push_ok) count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage needs no reset: entries are only read after being written
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/klotski_move_player.sv
// Replays a stream of blank-tile moves onto a registered 4x4 klotski board.
//  i_clk/i_rst   : clock, async active-high reset
//  i_load        : latch i_klotski, flush pending moves, clear count/illegal
//  i_pause       : hold off applying moves (tokens still accepted)
//  i_mv_valid/i_mv_dir/o_mv_ready : move token handshake
//  o_klotski/o_zero_pos/o_move_cnt/o_illegal/o_busy : board state and status
//  o_solved      : board equals goal; live only when KLOTSKI_SOLVED_DETECT_EN is
//                  defined, otherwise tied 0
module klotski_move_player
  import klotski_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  board_t           i_klotski,
  input  logic             i_pause,
  input  logic             i_mv_valid,
  input  logic [1:0]       i_mv_dir,
  output logic             o_mv_ready,
  output board_t           o_klotski,
  output pos_t             o_zero_pos,
  output logic [CNT_W-1:0] o_move_cnt,
  output logic             o_illegal,
  output logic             o_busy,
  output logic             o_solved
);

  state_e           state_q, state_d;
  board_t           board_q, board_d;
  pos_t             pos_q, pos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;

  logic       fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [1:0] fifo_data;

  assign o_mv_ready = ((state_q == ST_RUN) || (state_q == ST_ERR)) && !fifo_full;
  assign fifo_push  = i_mv_valid && o_mv_ready && !i_load;

  klotski_move_fifo #(.DEPTH(FIFO_DEPTH), .W(2)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_load),
    .i_push  (fifo_push),
    .i_data  (i_mv_dir),
    .i_pop   (fifo_pop),
    .o_data  (fifo_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // first blank in row-major order
  logic zfound;
  pos_t zpos;
  always_comb begin
    zfound = 1'b0;
    zpos   = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!zfound && board_q[r][c] == 4'd0) begin
          zfound = 1'b1;
          zpos   = {2'(r), 2'(c)};
        end
      end
    end
  end

  // neighbour the blank swaps with for the head token
  logic [1:0] row, col, nrow, ncol;
  logic       legal;
  always_comb begin
    row  = pos_q[1];
    col  = pos_q[0];
    nrow = row;
    ncol = col;
    legal = 1'b0;
    case (dir_e'(fifo_data))
      DIR_UP:    begin legal = (row != 2'd0); nrow = row - 2'd1; end
      DIR_DOWN:  begin legal = (row != 2'd3); nrow = row + 2'd1; end
      DIR_LEFT:  begin legal = (col != 2'd0); ncol = col - 2'd1; end
      default:   begin legal = (col != 2'd3); ncol = col + 2'd1; end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    pos_d     = pos_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    fifo_pop  = 1'b0;
    if (i_load) begin
      state_d   = ST_LOAD;
      board_d   = i_klotski;
      cnt_d     = '0;
      illegal_d = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (zfound) begin
            pos_d   = zpos;
            state_d = ST_RUN;
          end else begin
            illegal_d = 1'b1;
            state_d   = ST_ERR;
          end
        end
        ST_RUN: begin
          if (!fifo_empty && !i_pause) begin
            fifo_pop = 1'b1;
            if (legal) begin
              board_d[row][col]   = board_q[nrow][ncol];
              board_d[nrow][ncol] = 4'd0;
              pos_d               = {nrow, ncol};
              if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            end else begin
              illegal_d = 1'b1;
              state_d   = ST_ERR;
            end
          end
        end
        // board frozen; tokens are drained and discarded
        ST_ERR:  fifo_pop = !fifo_empty && !i_pause;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_EMPTY;
      board_q   <= '0;
      pos_q     <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      pos_q     <= pos_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef KLOTSKI_SOLVED_DETECT_EN
  // evaluated on the next board so it flips on the same edge as the board
  logic solved_q, solved_d;
  assign solved_d = is_solved(board_d);
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) solved_q <= 1'b0;
    else       solved_q <= solved_d;
  end
  assign o_solved = solved_q;
`else
  assign o_solved = 1'b0;
`endif

  assign o_klotski  = board_q;
  assign o_zero_pos = pos_q;
  assign o_move_cnt = cnt_q;
  assign o_illegal  = illegal_q;
  assign o_busy     = (state_q == ST_LOAD) || ((state_q == ST_RUN) && !fifo_empty);

endmodule

// File: tb/tb_klotski_move_player.sv
module tb_klotski_move_player;
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 10;

  logic                   i_clk = 1'b0;
  logic                   i_rst;
  logic                   i_load;
  logic [3:0][3:0][3:0]   i_klotski;
  logic                   i_pause;
  logic                   i_mv_valid;
  logic [1:0]             i_mv_dir;
  logic                   o_mv_ready;
  logic [3:0][3:0][3:0]   o_klotski;
  logic [1:0][1:0]        o_zero_pos;
  logic [CNT_W-1:0]       o_move_cnt;
  logic                   o_illegal;
  logic                   o_busy;
  logic                   o_solved;

  klotski_move_player #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(i_load), .i_klotski(i_klotski),
    .i_pause(i_pause), .i_mv_valid(i_mv_valid), .i_mv_dir(i_mv_dir),
    .o_mv_ready(o_mv_ready), .o_klotski(o_klotski), .o_zero_pos(o_zero_pos),
    .o_move_cnt(o_move_cnt), .o_illegal(o_illegal), .o_busy(o_busy),
    .o_solved(o_solved)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // reference model: plain integer grid, moves applied in push order
  int mb[4][4];
  int mzr, mzc, mcnt;
  bit mill, mblank;

  localparam logic [63:0] B2 = {4'd10,4'd1,4'd14,4'd12, 4'd6,4'd2,4'd9,4'd15,
                                4'd3,4'd7,4'd5,4'd4,    4'd0,4'd11,4'd8,4'd13};
  localparam logic [63:0] GOAL_SW = {4'd15,4'd0,4'd14,4'd13, 4'd12,4'd11,4'd10,4'd9,
                                     4'd8,4'd7,4'd6,4'd5,    4'd4,4'd3,4'd2,4'd1};
  localparam logic [63:0] NOBLANK = 64'h1111_2222_3333_4444;

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mpack();
    logic [63:0] v = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) v[r*16 + c*4 +: 4] = 4'(mb[r][c]);
    return v;
  endfunction

  function automatic logic mexp_solved();
`ifdef KLOTSKI_SOLVED_DETECT_EN
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (mb[r][c] != ((r == 3 && c == 3) ? 0 : 4*r + c + 1)) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_load(input logic [63:0] b);
    mblank = 0; mill = 0; mcnt = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mb[r][c] = int'(b[r*16 + c*4 +: 4]);
        if (!mblank && mb[r][c] == 0) begin mblank = 1; mzr = r; mzc = c; end
      end
    if (!mblank) mill = 1;
  endtask

  task automatic model_move(input int d);
    int nr, nc, t;
    if (mill) return;
    nr = mzr + ((d == 0) ? -1 : (d == 1) ? 1 : 0);
    nc = mzc + ((d == 2) ? -1 : (d == 3) ? 1 : 0);
    if (nr < 0 || nr > 3 || nc < 0 || nc > 3) begin mill = 1; return; end
    t = mb[nr][nc]; mb[nr][nc] = 0; mb[mzr][mzc] = t;
    mzr = nr; mzc = nc;
    if (mcnt < (1 << CNT_W) - 1) mcnt++;
  endtask

  task automatic do_load(input logic [63:0] b);
    i_load = 1; i_klotski = b;
    tick();
    i_load = 0;
    model_load(b);
    tick();
  endtask

  // push one token, waiting a bounded time for ready; random pause while waiting if asked
  task automatic push(input logic [1:0] d, input bit rnd_pause);
    int n = 0;
    if (rnd_pause) i_pause = ($urandom_range(0, 2) == 0);
    while (!o_mv_ready && n < 100) begin
      tick(); n++;
      if (rnd_pause) i_pause = ($urandom_range(0, 2) == 0);
    end
    check("push_ready", o_mv_ready, 1'b1);
    i_mv_valid = 1; i_mv_dir = d;
    tick();
    i_mv_valid = 0;
    model_move(int'(d));
  endtask

  task automatic drain();
    i_pause = 0;
    for (int i = 0; i < FIFO_DEPTH + 3; i++) tick();
  endtask

  task automatic check_all(input string tag);
    check({tag, "_board"}, o_klotski, mpack());
    check({tag, "_cnt"}, o_move_cnt, mcnt);
    check({tag, "_illegal"}, o_illegal, mill);
    check({tag, "_solved"}, o_solved, mexp_solved());
    check({tag, "_busy"}, o_busy, 1'b0);
    if (mblank) check({tag, "_pos"}, o_zero_pos, {2'(mzr), 2'(mzc)});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pb;
    int p[16];
    int t, j, d;

    i_rst = 1; i_load = 0; i_klotski = '0; i_pause = 0; i_mv_valid = 0; i_mv_dir = 0;
    tick(); tick();
    // 1: reset state
    check("rst_ready", o_mv_ready, 1'b0);
    check("rst_board", o_klotski, 64'd0);
    check("rst_cnt", o_move_cnt, 0);
    check("rst_illegal", o_illegal, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_pos", o_zero_pos, 4'd0);
    check("rst_solved", o_solved, 1'b0);
    @(negedge i_clk); i_rst = 0;
    tick();
    check("empty_ready", o_mv_ready, 1'b0);

    // 2: single legal DOWN, with latency
    i_load = 1; i_klotski = B2;
    tick();
    i_load = 0; model_load(B2);
    check("load_busy", o_busy, 1'b1);
    check("load_ready", o_mv_ready, 1'b0);
    tick();
    check("t2_pos0", o_zero_pos, 4'b0011);
    push(2'd1, 0);
    check("t2_lat_cnt", o_move_cnt, 0);
    check("t2_lat_busy", o_busy, 1'b1);
    tick();
    check("t2_cnt", o_move_cnt, 1);
    check("t2_pos", o_zero_pos, 4'b0111);
    check("t2_b03", o_klotski[0][3], 4'd3);
    check("t2_b13", o_klotski[1][3], 4'd0);
    check_all("t2");

    // 3: illegal UP then DOWN discarded
    do_load(B2);
    push(2'd0, 0);
    tick();
    check("t3_illegal", o_illegal, 1'b1);
    push(2'd1, 0);
    tick(); tick();
    check("t3_ready_err", o_mv_ready, 1'b1);
    check("t3_board_b2", o_klotski, B2);
    check_all("t3");

    // loaded board without blank
    do_load(NOBLANK);
    check("nb_illegal", o_illegal, 1'b1);
    check("nb_ready", o_mv_ready, 1'b1);
    push(2'd1, 0);
    drain();
    check_all("nb");

    // 4: fill FIFO while paused, then release
    do_load(B2);
    i_pause = 1;
    for (int i = 0; i < FIFO_DEPTH; i++) push((i % 2 == 0) ? 2'd2 : 2'd3, 0);
    check("t4_full_ready", o_mv_ready, 1'b0);
    i_mv_valid = 1; i_mv_dir = 2'd2;
    tick();
    i_mv_valid = 0;
    check("t4_paused_cnt", o_move_cnt, 0);
    check("t4_paused_busy", o_busy, 1'b1);
    i_pause = 0;
    for (int i = 0; i < FIFO_DEPTH - 1; i++) tick();
    check("t4_cnt7", o_move_cnt, FIFO_DEPTH - 1);
    check("t4_busy7", o_busy, 1'b1);
    tick();
    check("t4_cnt8", o_move_cnt, FIFO_DEPTH);
    check("t4_busy_fall", o_busy, 1'b0);
    tick();
    check_all("t4");

    // 5: solve from goal with last two tiles swapped
    do_load(GOAL_SW);
    check("t5_pre_solved", o_solved, 1'b0);
    push(2'd3, 0);
    tick();
    check_all("t5");
    check("t5_cnt", o_move_cnt, 1);

    // 6: reload mid-drain
    do_load(B2);
    i_pause = 1;
    for (int i = 0; i < 4; i++) push((i % 2 == 0) ? 2'd2 : 2'd3, 0);
    i_pause = 0;
    tick(); tick();
    check("t6_mid_cnt", o_move_cnt, 2);
    check("t6_mid_busy", o_busy, 1'b1);
    i_load = 1; i_klotski = GOAL_SW;
    tick();
    i_load = 0; model_load(GOAL_SW);
    check("t6_cnt0", o_move_cnt, 0);
    check("t6_board", o_klotski, GOAL_SW);
    check("t6_busy_load", o_busy, 1'b1);
    tick();
    check("t6_ready", o_mv_ready, 1'b1);
    tick(); tick();
    check_all("t6");

    // random boards and move streams, mostly legal
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 16; i++) p[i] = i;
      for (int i = 15; i > 0; i--) begin
        j = $urandom_range(0, i); t = p[i]; p[i] = p[j]; p[j] = t;
      end
      pb = '0;
      for (int i = 0; i < 16; i++) pb[i*4 +: 4] = 4'(p[i]);
      do_load(pb);
      for (int k = 0; k < 24; k++) begin
        d = $urandom_range(0, 3);
        if ($urandom_range(0, 7) != 0) begin
          // pick a legal direction from the model's current blank
          while ((d == 0 && mzr == 0) || (d == 1 && mzr == 3) ||
                 (d == 2 && mzc == 0) || (d == 3 && mzc == 3)) d = $urandom_range(0, 3);
        end
        push(2'(d), 1);
      end
      drain();
      check_all("rand");
    end

    // reset mid-run discards everything
    do_load(B2);
    i_pause = 1;
    push(2'd1, 0);
    i_rst = 1; #1;
    check("mrst_board", o_klotski, 64'd0);
    check("mrst_ready", o_mv_ready, 1'b0);
    tick();
    i_rst = 0; i_pause = 0;
    tick(); tick();
    check("mrst_cnt", o_move_cnt, 0);
    check("mrst_busy", o_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
